// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running x/y counters plus sync, blanking and
// frame-start flags delayed to line up with a pipelined downstream pixel source.
module vga_timing #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic [2:0]  i_pixel,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [2:0]  o_rgb,
    output logic        o_frame_start
);
    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DEPTH    = PIPE_DELAY + 1;

    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic             frame_raw;
    logic             act_dly;
    logic [DEPTH-1:0] hs_sr;
    logic [DEPTH-1:0] vs_sr;
    logic [DEPTH-1:0] fs_sr;

    // Raster counters: y advances only on the x wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (x == CW'(H_TOTAL - 1)) begin
            x <= '0;
            y <= (y == CW'(V_TOTAL - 1)) ? '0 : y + CW'(1);
        end else begin
            x <= x + CW'(1);
        end
    end

    always_comb begin
        active    = (x < CW'(H_ACTIVE)) && (y < CW'(V_ACTIVE));
        hs_raw    = !((x >= CW'(HS_START)) && (x < CW'(HS_END)));
        vs_raw    = !((y >= CW'(VS_START)) && (y < CW'(VS_END)));
        frame_raw = (x == '0) && (y == '0);
    end

    // Sync/frame delay lines; the last stage drives the pins directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sr <= '1;
            vs_sr <= '1;
            fs_sr <= '0;
        end else begin
            hs_sr <= (hs_sr << 1) | DEPTH'(hs_raw);
            vs_sr <= (vs_sr << 1) | DEPTH'(vs_raw);
            fs_sr <= (fs_sr << 1) | DEPTH'(frame_raw);
        end
    end

    assign o_hsync       = hs_sr[DEPTH-1];
    assign o_vsync       = vs_sr[DEPTH-1];
    assign o_frame_start = fs_sr[DEPTH-1];

    // Active flag delayed to match the pixel arriving on i_pixel
    if (PIPE_DELAY == 0) begin : g_act_direct
        assign act_dly = active;
    end else begin : g_act_pipe
        logic [PIPE_DELAY-1:0] act_sr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                act_sr <= '0;
            end else begin
                act_sr <= (act_sr << 1) | PIPE_DELAY'(active);
            end
        end

        assign act_dly = act_sr[PIPE_DELAY-1];
    end

    // Pixel register with blanking folded in, landing on the same edge as the syncs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rgb <= 3'b000;
        end else begin
            o_rgb <= act_dly ? i_pixel : 3'b000;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: small rasters at PIPE_DELAY 0/2/4 plus a
// default-size instance, scoreboarded against an independent raster model.
module tb_vga_timing;
    localparam int NDUT = 4;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] rgb;
    } exp_t;

    typedef struct {
        int          adv;
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] sx;
        logic [10:0] sy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [10:0] xo   [NDUT];
    logic [10:0] yo   [NDUT];
    logic [2:0]  pix  [NDUT];
    logic        hs_o [NDUT];
    logic        vs_o [NDUT];
    logic [2:0]  rgb_o[NDUT];
    logic        fs_o [NDUT];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vga_timing #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                 .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0))
    u_d0 (.clk(clk), .rst(rst), .x(xo[0]), .y(yo[0]), .i_pixel(pix[0]),
          .o_hsync(hs_o[0]), .o_vsync(vs_o[0]), .o_rgb(rgb_o[0]), .o_frame_start(fs_o[0]));

    vga_timing #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                 .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(2))
    u_d2 (.clk(clk), .rst(rst), .x(xo[1]), .y(yo[1]), .i_pixel(pix[1]),
          .o_hsync(hs_o[1]), .o_vsync(vs_o[1]), .o_rgb(rgb_o[1]), .o_frame_start(fs_o[1]));

    vga_timing #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                 .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(4))
    u_d4 (.clk(clk), .rst(rst), .x(xo[2]), .y(yo[2]), .i_pixel(pix[2]),
          .o_hsync(hs_o[2]), .o_vsync(vs_o[2]), .o_rgb(rgb_o[2]), .o_frame_start(fs_o[2]));

    vga_timing u_def (.clk(clk), .rst(rst), .x(xo[3]), .y(yo[3]), .i_pixel(pix[3]),
          .o_hsync(hs_o[3]), .o_vsync(vs_o[3]), .o_rgb(rgb_o[3]), .o_frame_start(fs_o[3]));

    // Per-instance raster geometry (index 3 is the default 640x480 instance)
    function automatic int pdk(int k);
        case (k)
            0:       return 0;
            1:       return 2;
            2:       return 4;
            default: return 2;
        endcase
    endfunction
    function automatic int ha (int k); return (k == 3) ? 640 : 16; endfunction
    function automatic int hf (int k); return (k == 3) ? 16  : 4;  endfunction
    function automatic int hsw(int k); return (k == 3) ? 96  : 6;  endfunction
    function automatic int hb (int k); return (k == 3) ? 48  : 6;  endfunction
    function automatic int va (int k); return (k == 3) ? 480 : 10; endfunction
    function automatic int vf (int k); return (k == 3) ? 10  : 2;  endfunction
    function automatic int vsw(int k); return (k == 3) ? 2   : 2;  endfunction
    function automatic int vb (int k); return (k == 3) ? 33  : 3;  endfunction
    function automatic int htot(int k); return ha(k) + hf(k) + hsw(k) + hb(k); endfunction
    function automatic int vtot(int k); return va(k) + vf(k) + vsw(k) + vb(k); endfunction

    function automatic logic [2:0] pat(int rx, int ry);
        return 3'(rx ^ (ry * 3));
    endfunction

    function automatic exp_t model(int k, int rx, int ry);
        exp_t e;
        logic act;
        act   = (rx < ha(k)) && (ry < va(k));
        e.hs  = !((rx >= ha(k) + hf(k)) && (rx < ha(k) + hf(k) + hsw(k)));
        e.vs  = !((ry >= va(k) + vf(k)) && (ry < va(k) + vf(k) + vsw(k)));
        e.fs  = (rx == 0) && (ry == 0);
        e.rgb = act ? pat(rx, ry) : 3'b000;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk($sformatf("d%0d.%s.hsync", k, tag), int'(hs_o[k]), 1);
        chk($sformatf("d%0d.%s.vsync", k, tag), int'(vs_o[k]), 1);
        chk($sformatf("d%0d.%s.rgb", k, tag), int'(rgb_o[k]), 0);
        chk($sformatf("d%0d.%s.fstart", k, tag), int'(fs_o[k]), 0);
    endtask

    // Starts in cycle 0 just after reset release; ends one edge+1 into cycle n
    task automatic run_sb(input int n);
        exp_t       sbq [NDUT][$];
        logic [2:0] hist[NDUT][$];
        int         rx[NDUT];
        int         ry[NDUT];
        exp_t       e;
        for (int k = 0; k < NDUT; k++) begin
            rx[k] = 0;
            ry[k] = 0;
        end
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < NDUT; k++) begin
                hist[k].push_front(pat(rx[k], ry[k]));
                pix[k] = (hist[k].size() > pdk(k)) ? hist[k][pdk(k)] : 3'b000;
                if (hist[k].size() > pdk(k) + 1) void'(hist[k].pop_back());
                sbq[k].push_back(model(k, rx[k], ry[k]));
            end
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("d%0d.x", k), int'(xo[k]), rx[k]);
                chk($sformatf("d%0d.y", k), int'(yo[k]), ry[k]);
                if (sbq[k].size() == pdk(k) + 2) begin
                    e = sbq[k].pop_front();
                    chk($sformatf("d%0d.hsync", k), int'(hs_o[k]), int'(e.hs));
                    chk($sformatf("d%0d.vsync", k), int'(vs_o[k]), int'(e.vs));
                    chk($sformatf("d%0d.fstart", k), int'(fs_o[k]), int'(e.fs));
                    chk($sformatf("d%0d.rgb", k), int'(rgb_o[k]), int'(e.rgb));
                end else begin
                    chk_idle(k, "lat");
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                rx[k]++;
                if (rx[k] == htot(k)) begin
                    rx[k] = 0;
                    ry[k]++;
                    if (ry[k] == vtot(k)) ry[k] = 0;
                end
            end
        end
    endtask

    initial begin
        vec_t vec[9];
        vec[0] = '{0,   11'd0,   11'd0, 11'd0,  11'd0};
        vec[1] = '{1,   11'd1,   11'd0, 11'd1,  11'd0};
        vec[2] = '{30,  11'd31,  11'd0, 11'd31, 11'd0};
        vec[3] = '{1,   11'd32,  11'd0, 11'd0,  11'd1};
        vec[4] = '{511, 11'd543, 11'd0, 11'd31, 11'd16};
        vec[5] = '{1,   11'd544, 11'd0, 11'd0,  11'd0};
        vec[6] = '{255, 11'd799, 11'd0, 11'd31, 11'd7};
        vec[7] = '{1,   11'd0,   11'd1, 11'd0,  11'd8};
        vec[8] = '{200, 11'd200, 11'd1, 11'd8,  11'd14};

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) pix[k] = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d.rst.x", k), int'(xo[k]), 0);
            chk($sformatf("d%0d.rst.y", k), int'(yo[k]), 0);
            chk_idle(k, "rst");
        end

        // Long scoreboarded run: three small frames and two default-size lines
        rst = 1'b0;
        run_sb(1700);

        // Table of counter positions after known numbers of clocks
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) pix[k] = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            repeat (vec[i].adv) @(posedge clk);
            #1;
            chk($sformatf("vec%0d.def.x", i), int'(xo[3]), int'(vec[i].dx));
            chk($sformatf("vec%0d.def.y", i), int'(yo[3]), int'(vec[i].dy));
            chk($sformatf("vec%0d.small.x", i), int'(xo[0]), int'(vec[i].sx));
            chk($sformatf("vec%0d.small.y", i), int'(yo[0]), int'(vec[i].sy));
        end

        // Reset landing inside both sync pulses, then timing must resume cleanly
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_sb(439);
        @(negedge clk);
        chk("pre.d2.x", int'(xo[1]), 23);
        chk("pre.d2.y", int'(yo[1]), 13);
        chk("pre.d2.hsync", int'(hs_o[1]), 0);
        chk("pre.d2.vsync", int'(vs_o[1]), 0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d.async.x", k), int'(xo[k]), 0);
            chk($sformatf("d%0d.async.y", k), int'(yo[k]), 0);
            chk($sformatf("d%0d.async.hsync", k), int'(hs_o[k]), 1);
            chk($sformatf("d%0d.async.vsync", k), int'(vs_o[k]), 1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_sb(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
